// File: rtl/commit_trace_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// commit_trace_unit: merges fetch/writeback/store events into one commit
// record per retired instruction, buffered in a show-ahead FIFO.  Rev 1.0
// ----------------------------------------------------------------------------
module commit_trace_unit #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            fetch_valid_i,
   input  logic [XLEN-1:0] fetch_pc_i,
   input  logic [XLEN-1:0] fetch_instr_i,
   input  logic            wb_valid_i,
   input  logic [4:0]      wb_addr_i,
   input  logic [XLEN-1:0] wb_data_i,
   input  logic            st_valid_i,
   input  logic [XLEN-1:0] st_addr_i,
   input  logic [XLEN-1:0] st_data_i,
   input  logic            retire_i,
   input  logic            ready_i,
   output logic            update_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] instr_o,
   output logic [4:0]      reg_addr_o,
   output logic [XLEN-1:0] reg_data_o,
   output logic [XLEN-1:0] mem_addr_o,
   output logic [XLEN-1:0] mem_data_o,
   output logic            mem_wrt_o,
   output logic            full_o,
   output logic            overflow_o,
   output logic            err_o
);
   localparam int AW = $clog2(DEPTH);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
      logic [4:0]      rd;
      logic [XLEN-1:0] rdata;
      logic [XLEN-1:0] maddr;
      logic [XLEN-1:0] mdata;
      logic            mwrt;
   } rec_t;

   typedef enum logic {IDLE = 1'b0, INFLIGHT = 1'b1} state_t;

   state_t      state, state_nxt;
   rec_t        stage, rec_push, head;
   rec_t        mem [DEPTH];
   logic        push, load_fetch, err_set;
   logic        full, empty, pop, wr_en, drop;
   logic        overflow, err;
   logic [AW:0] wr_ptr, rd_ptr;

   // Staged record with same-cycle wb/st events folded in; x0 writes read as zero.
   always_comb begin
      rec_push = stage;
      if (wb_valid_i) begin
         rec_push.rd    = wb_addr_i;
         rec_push.rdata = (wb_addr_i == 5'd0) ? '0 : wb_data_i;
      end
      if (st_valid_i) begin
         rec_push.maddr = st_addr_i;
         rec_push.mdata = st_data_i;
         rec_push.mwrt  = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      push       = 1'b0;
      load_fetch = 1'b0;
      err_set    = 1'b0;
      case (state)
         IDLE: begin
            if (fetch_valid_i) begin
               load_fetch = 1'b1;
               state_nxt  = INFLIGHT;
            end
            if (retire_i || wb_valid_i || st_valid_i) err_set = 1'b1;
         end
         INFLIGHT: begin
            if (retire_i) begin
               push = 1'b1;
               if (fetch_valid_i) load_fetch = 1'b1;
               else               state_nxt  = IDLE;
            end else if (fetch_valid_i) begin
               load_fetch = 1'b1;
               err_set    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage <= '0;
      end else if (load_fetch) begin
         stage       <= '0;
         stage.pc    <= fetch_pc_i;
         stage.instr <= fetch_instr_i;
      end else if (state == INFLIGHT) begin
         stage <= rec_push;
      end
   end

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);
   assign pop   = !empty && ready_i;
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
         err      <= 1'b0;
      end else begin
         if (wr_en)   wr_ptr   <= wr_ptr + {{AW{1'b0}}, 1'b1};
         if (pop)     rd_ptr   <= rd_ptr + {{AW{1'b0}}, 1'b1};
         if (drop)    overflow <= 1'b1;
         if (err_set) err      <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem[wr_ptr[AW-1:0]] <= rec_push;
   end

   assign head       = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign update_o   = !empty;
   assign pc_o       = head.pc;
   assign instr_o    = head.instr;
   assign reg_addr_o = head.rd;
   assign reg_data_o = head.rdata;
   assign mem_addr_o = head.maddr;
   assign mem_data_o = head.mdata;
   assign mem_wrt_o  = head.mwrt;
   assign full_o     = full;
   assign overflow_o = overflow;
   assign err_o      = err;
endmodule
`default_nettype wire

// File: tb/tb_commit_trace_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_commit_trace_unit: directed scenarios with hand-computed commit records.
// ----------------------------------------------------------------------------
module tb_commit_trace_unit;
   logic        clk = 1'b0;
   logic        rst_i, fetch_valid_i, wb_valid_i, st_valid_i, retire_i, ready_i;
   logic [31:0] fetch_pc_i, fetch_instr_i, wb_data_i, st_addr_i, st_data_i;
   logic [4:0]  wb_addr_i;
   logic        update_o, mem_wrt_o, full_o, overflow_o, err_o;
   logic [31:0] pc_o, instr_o, reg_data_o, mem_addr_o, mem_data_o;
   logic [4:0]  reg_addr_o;
   int          checks = 0;
   int          failures = 0;

   always #5 clk = ~clk;

   commit_trace_unit #(.XLEN(32), .DEPTH(4)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .fetch_valid_i(fetch_valid_i), .fetch_pc_i(fetch_pc_i), .fetch_instr_i(fetch_instr_i),
      .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
      .st_valid_i(st_valid_i), .st_addr_i(st_addr_i), .st_data_i(st_data_i),
      .retire_i(retire_i), .ready_i(ready_i),
      .update_o(update_o), .pc_o(pc_o), .instr_o(instr_o),
      .reg_addr_o(reg_addr_o), .reg_data_o(reg_data_o),
      .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_wrt_o(mem_wrt_o),
      .full_o(full_o), .overflow_o(overflow_o), .err_o(err_o)
   );

   // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      fetch_valid_i = 0; fetch_pc_i = 0; fetch_instr_i = 0;
      wb_valid_i = 0; wb_addr_i = 0; wb_data_i = 0;
      st_valid_i = 0; st_addr_i = 0; st_data_i = 0;
      retire_i = 0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst_i = 1; tick(); rst_i = 0;
   endtask

   task automatic set_fetch(input logic [31:0] pc, input logic [31:0] ins);
      fetch_valid_i = 1; fetch_pc_i = pc; fetch_instr_i = ins;
   endtask

   task automatic test_reset();
      ready_i = 0;
      rst_i = 1; idle_inputs(); tick(); tick(); rst_i = 0;
      checks++; if ({update_o, full_o, overflow_o, err_o} !== 4'b0) begin failures++;
         $display("FAIL reset_flags got=%b want=0000", {update_o, full_o, overflow_o, err_o}); end
      checks++; if ({pc_o, instr_o, reg_data_o, mem_addr_o, mem_data_o, reg_addr_o, mem_wrt_o} !== '0) begin failures++;
         $display("FAIL reset_record got pc=%h instr=%h rd=%0d", pc_o, instr_o, reg_addr_o); end
   endtask

   task automatic test_writeback();
      set_fetch(32'h8000_0000, 32'h0050_0093); tick();
      idle_inputs(); wb_valid_i = 1; wb_addr_i = 5'd1; wb_data_i = 32'h5; tick();
      idle_inputs(); retire_i = 1; ready_i = 1; tick();
      idle_inputs();
      checks++; if (update_o !== 1'b1 || pc_o !== 32'h8000_0000 || instr_o !== 32'h0050_0093) begin failures++;
         $display("FAIL wb_head got upd=%b pc=%h instr=%h want 1 80000000 00500093", update_o, pc_o, instr_o); end
      checks++; if (reg_addr_o !== 5'd1 || reg_data_o !== 32'h5 || mem_wrt_o !== 1'b0) begin failures++;
         $display("FAIL wb_fields got rd=%0d data=%h mw=%b want 1 5 0", reg_addr_o, reg_data_o, mem_wrt_o); end
      tick();
      checks++; if (update_o !== 1'b0) begin failures++;
         $display("FAIL wb_drain got upd=%b want 0", update_o); end
   endtask

   task automatic test_store();
      set_fetch(32'h8000_0004, 32'h0011_2023); tick();
      idle_inputs(); st_valid_i = 1; st_addr_i = 32'h8000_0000; st_data_i = 32'h5; retire_i = 1; tick();
      idle_inputs();
      checks++; if (update_o !== 1'b1 || pc_o !== 32'h8000_0004 || mem_wrt_o !== 1'b1) begin failures++;
         $display("FAIL st_head got upd=%b pc=%h mw=%b want 1 80000004 1", update_o, pc_o, mem_wrt_o); end
      checks++; if (mem_addr_o !== 32'h8000_0000 || mem_data_o !== 32'h5 || reg_addr_o !== 5'd0) begin failures++;
         $display("FAIL st_fields got ma=%h md=%h rd=%0d want 80000000 5 0", mem_addr_o, mem_data_o, reg_addr_o); end
      tick();
      checks++; if (update_o !== 1'b0) begin failures++;
         $display("FAIL st_drain got upd=%b want 0", update_o); end
   endtask

   task automatic test_overflow();
      do_reset();
      ready_i = 0;
      for (int i = 0; i < 5; i++) begin
         set_fetch(32'h100 + 32'(4 * i), 32'(i + 1)); tick();
         idle_inputs(); retire_i = 1; wb_valid_i = 1; wb_addr_i = 5'(i + 1); wb_data_i = 32'h10 + 32'(i); tick();
         idle_inputs();
         if (i == 2) begin checks++; if (full_o !== 1'b0) begin failures++;
            $display("FAIL ovf_not_full3 got=%b want 0", full_o); end end
         if (i == 3) begin checks++; if (full_o !== 1'b1 || overflow_o !== 1'b0) begin failures++;
            $display("FAIL ovf_full4 got full=%b ovf=%b want 1 0", full_o, overflow_o); end end
         if (i == 4) begin checks++; if (overflow_o !== 1'b1 || full_o !== 1'b1) begin failures++;
            $display("FAIL ovf_drop5 got ovf=%b full=%b want 1 1", overflow_o, full_o); end end
      end
      ready_i = 1;
      for (int k = 0; k < 4; k++) begin
         checks++; if (update_o !== 1'b1 || pc_o !== 32'h100 + 32'(4 * k) || reg_addr_o !== 5'(k + 1)
                       || reg_data_o !== 32'h10 + 32'(k)) begin failures++;
            $display("FAIL ovf_pop%0d got upd=%b pc=%h rd=%0d data=%h", k, update_o, pc_o, reg_addr_o, reg_data_o); end
         tick();
      end
      checks++; if (update_o !== 1'b0 || overflow_o !== 1'b1) begin failures++;
         $display("FAIL ovf_fifth_absent got upd=%b ovf=%b want 0 1", update_o, overflow_o); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      ready_i = 0;
      for (int i = 0; i < 4; i++) begin
         set_fetch(32'h200 + 32'(4 * i), 32'hA0 + 32'(i)); tick();
         idle_inputs(); retire_i = 1; tick(); idle_inputs();
      end
      set_fetch(32'h210, 32'hA4); tick();
      ready_i = 1;
      for (int c = 0; c < 9; c++) begin
         idle_inputs();
         if (c < 4) begin set_fetch(32'h214 + 32'(4 * c), 32'hA5 + 32'(c)); retire_i = 1; end
         else if (c == 4) retire_i = 1;
         checks++; if (update_o !== 1'b1 || pc_o !== 32'h200 + 32'(4 * c) || instr_o !== 32'hA0 + 32'(c)
                       || full_o !== (c <= 5)) begin failures++;
            $display("FAIL b2b_c%0d got upd=%b pc=%h instr=%h full=%b", c, update_o, pc_o, instr_o, full_o); end
         tick();
      end
      idle_inputs();
      checks++; if (update_o !== 1'b0 || overflow_o !== 1'b0 || err_o !== 1'b0) begin failures++;
         $display("FAIL b2b_end got upd=%b ovf=%b err=%b want 0 0 0", update_o, overflow_o, err_o); end
   endtask

   task automatic test_protocol_errors();
      do_reset();
      ready_i = 1;
      retire_i = 1; tick(); idle_inputs();
      checks++; if (err_o !== 1'b1 || update_o !== 1'b0) begin failures++;
         $display("FAIL err_idle_retire got err=%b upd=%b want 1 0", err_o, update_o); end
      set_fetch(32'h400, 32'h0000_0013); tick();
      idle_inputs(); wb_valid_i = 1; wb_addr_i = 5'd5; wb_data_i = 32'h55; tick();
      idle_inputs(); wb_valid_i = 1; wb_addr_i = 5'd0; wb_data_i = 32'hDEAD; retire_i = 1; tick();
      idle_inputs();
      checks++; if (update_o !== 1'b1 || pc_o !== 32'h400 || reg_addr_o !== 5'd0 || reg_data_o !== 32'h0) begin failures++;
         $display("FAIL err_x0_wb got upd=%b pc=%h rd=%0d data=%h want 1 400 0 0", update_o, pc_o, reg_addr_o, reg_data_o); end
      tick();
   endtask

   task automatic test_reset_inflight();
      do_reset();
      ready_i = 0;
      retire_i = 1; tick(); idle_inputs();
      for (int i = 0; i < 2; i++) begin
         set_fetch(32'h300 + 32'(4 * i), 32'h1); tick();
         idle_inputs(); retire_i = 1; tick(); idle_inputs();
      end
      set_fetch(32'h308, 32'h2); tick(); idle_inputs();
      checks++; if (update_o !== 1'b1 || err_o !== 1'b1) begin failures++;
         $display("FAIL rst_pre got upd=%b err=%b want 1 1", update_o, err_o); end
      rst_i = 1; tick(); rst_i = 0;
      checks++; if ({update_o, full_o, overflow_o, err_o} !== 4'b0) begin failures++;
         $display("FAIL rst_mid got=%b want 0000", {update_o, full_o, overflow_o, err_o}); end
      retire_i = 1; tick(); idle_inputs();
      set_fetch(32'h500, 32'h3); tick();
      idle_inputs(); retire_i = 1; tick(); idle_inputs();
      checks++; if (update_o !== 1'b1 || pc_o !== 32'h500 || instr_o !== 32'h3) begin failures++;
         $display("FAIL rst_fresh got upd=%b pc=%h instr=%h want 1 500 3", update_o, pc_o, instr_o); end
      ready_i = 1; tick();
      checks++; if (update_o !== 1'b0) begin failures++;
         $display("FAIL rst_fresh_single got upd=%b want 0", update_o); end
   endtask

   initial begin
      rst_i = 1; ready_i = 0; idle_inputs();
      test_reset();
      test_writeback();
      test_store();
      test_overflow();
      test_back_to_back();
      test_protocol_errors();
      test_reset_inflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/commit_trace_unit.md
Name: commit_trace_unit

Overview:
- Sits inside riscv_multicycle and produces the per-instruction commit trace that the trace logger consumes.
- Collects the fetch, writeback and store events that the multicycle FSM raises over several cycles into one record per retired instruction.
- Buffers the records in a small FIFO.
- Presents each record as a show-ahead entry, qualified by update_o and drained by ready_i.

Parameters:
XLEN, riscv_pkg::XLEN, data/address width.
DEPTH, 4, FIFO entries; power of two, >= 2.

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous reset, active-high
fetch_valid_i  in  1  instruction fetched; fetch_pc_i/fetch_instr_i valid
fetch_pc_i  in  XLEN  pc of fetched instruction
fetch_instr_i  in  XLEN  fetched instruction word
wb_valid_i  in  1  register writeback this cycle
wb_addr_i  in  5  destination register
wb_data_i  in  XLEN  writeback data
st_valid_i  in  1  memory store this cycle
st_addr_i  in  XLEN  store address
st_data_i  in  XLEN  store data
retire_i  in  1  current instruction completes this cycle
ready_i  in  1  consumer accepts head record
update_o  out  1  head record valid (FIFO not empty)
pc_o  out  XLEN  head record pc
instr_o  out  XLEN  head record instruction
reg_addr_o  out  5  head record rd; 0 = no write
reg_data_o  out  XLEN  head record rd data; 0 when reg_addr_o = 0
mem_addr_o  out  XLEN  head record store address
mem_data_o  out  XLEN  head record store data
mem_wrt_o  out  1  head record contains a store
full_o  out  1  FIFO full (core may stall retire on it)
overflow_o  out  1  sticky: a record was dropped
err_o  out  1  sticky: protocol violation seen

Behaviour:

Reset:
- rst_i sampled high at a clock edge puts the FSM in IDLE, empties the FIFO, and clears the staging registers, overflow_o and err_o.
- Every output reads 0 while in reset and on the cycle after reset.
- Reset mid-instruction discards the staged record and all buffered records.

Staging FSM, states IDLE and INFLIGHT:
- IDLE + fetch_valid_i: latch pc/instr, clear the rd/data/store fields, go to INFLIGHT.
- INFLIGHT + wb_valid_i: latch rd/data. If several occur, the last one wins.
- INFLIGHT + wb_valid_i with wb_addr_i = 0: record rd = 0, data = 0.
- INFLIGHT + st_valid_i: latch addr/data and set the store flag. Last one wins.
- INFLIGHT + retire_i: push the staged record and go to IDLE.
- wb/st events in the same cycle as retire_i are bypassed into the pushed record.
- INFLIGHT + retire_i + fetch_valid_i in the same cycle: push the current record, latch the new fetch, stay in INFLIGHT. This gives back-to-back retire at 1 per cycle.
- IDLE + retire_i: no push; set err_o.
- IDLE + wb_valid_i or st_valid_i: ignored; set err_o.
- INFLIGHT + fetch_valid_i without retire_i: set err_o; the new fetch overwrites the staged record (no push).

FIFO:
- Pointers are log2(DEPTH)+1 bits wide. Full = MSBs differ and low bits equal. Empty = pointers equal.
- Show-ahead output: update_o = !empty, and all record outputs are driven from the head entry.
- Record outputs are 0 while empty.
- Pop occurs on update_o && ready_i.
- Push-to-output latency: a record pushed at edge N is visible with update_o = 1 after edge N when the FIFO was empty. There is no combinational path from inputs to outputs.
- Push while full with a pop in the same cycle: accepted; occupancy unchanged.
- Push while full with no pop: record dropped, overflow_o set. The FIFO contents are unchanged.
- Pop while empty: no effect.
- Pointers wrap modulo 2*DEPTH.
- full_o reflects the registered occupancy and does not account for a same-cycle pop.

Test Plan:
1. Reset, then fetch(pc=0x80000000, instr=0x00500093), wb(x1, 0x5) in the next cycle, retire one cycle later, ready_i = 1 -> one cycle after retire: update_o = 1, pc_o = 0x80000000, reg_addr_o = 1, reg_data_o = 0x5, mem_wrt_o = 0. Then update_o = 0.
2. Store: fetch(pc=0x80000004, instr=0x00112023), st(0x80000000, 0x5) in the same cycle as retire -> record has mem_wrt_o = 1, mem_addr_o = 0x80000000, mem_data_o = 0x5, reg_addr_o = 0.
3. ready_i = 0, DEPTH = 4, 5 instructions retired -> full_o = 1 after the 4th, overflow_o = 1 after the 5th. Raising ready_i then yields exactly 4 records in order; the 5th is absent.
4. With the FIFO full, hold ready_i = 1 while retiring back-to-back with fetch+retire every cycle -> no drop, overflow_o stays 0, records come out in retire order.
5. Protocol errors: retire_i in IDLE -> err_o = 1, no record. wb with x0 -> reg_addr_o = 0, reg_data_o = 0.
6. Assert rst_i while INFLIGHT with 2 records buffered -> next cycle update_o = 0, full_o = 0, overflow_o = 0, err_o = 0. The following fetch/retire produces a fresh record.
